// File: rtl/cordic_pkg.sv
// Constants shared by the CORDIC rotation and vectoring blocks: binary-angle arctangent
// table, 90-degree angle, inverse gain and FSM state type (COMP exists with CORDIC_GAIN_COMP_EN).
package cordic_pkg;

    // 1/K for the asymptotic CORDIC gain, Q0.32
    localparam logic [31:0] INV_GAIN_Q32 = 32'h9B74EDA8;

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_COMP, ST_DONE} cordic_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} cordic_state_e;
`endif

    // atan(2^-k) with 2^32 = 360 degrees
    function automatic logic [31:0] atan_q32(input int k);
        logic [31:0] a;
        case (k)
            0:  a = 32'd536870912;
            1:  a = 32'd316933406;
            2:  a = 32'd167458907;
            3:  a = 32'd85004756;
            4:  a = 32'd42667331;
            5:  a = 32'd21354465;
            6:  a = 32'd10679838;
            7:  a = 32'd5340245;
            8:  a = 32'd2670163;
            9:  a = 32'd1335087;
            10: a = 32'd667544;
            11: a = 32'd333772;
            12: a = 32'd166886;
            13: a = 32'd83443;
            14: a = 32'd41722;
            15: a = 32'd20861;
            16: a = 32'd10430;
            17: a = 32'd5215;
            18: a = 32'd2608;
            19: a = 32'd1304;
            20: a = 32'd652;
            21: a = 32'd326;
            22: a = 32'd163;
            23: a = 32'd81;
            24: a = 32'd41;
            25: a = 32'd20;
            26: a = 32'd10;
            27: a = 32'd5;
            28: a = 32'd3;
            29: a = 32'd1;
            30: a = 32'd1;
            default: a = 32'd0;
        endcase
        return a;
    endfunction

    // Round-to-nearest rescale of a Q0.32 value to `width` fraction bits
    function automatic logic [31:0] scale_q32(input logic [31:0] v, input int width);
        logic [32:0] rounded;
        if (width >= 32) return v;
        rounded = {1'b0, v} + (33'd1 << (31 - width));
        return 32'(rounded >> (32 - width));
    endfunction

    function automatic logic [31:0] atan_angle(input int k, input int width);
        return scale_q32(atan_q32(k), width);
    endfunction

    function automatic logic [31:0] angle_90(input int width);
        return 32'd1 << (width - 2);
    endfunction

    function automatic logic [31:0] inv_gain(input int width);
        return scale_q32(INV_GAIN_Q32, width);
    endfunction

endpackage

// File: rtl/cordic_vec_microrot.sv
// One combinational vectoring micro-rotation: drives y toward zero and accumulates the angle in z.
module cordic_vec_microrot
    import cordic_pkg::*;
#(
    parameter int NUM_WIDTH = 24,
    parameter int CNT_W     = 4
) (
    input  logic signed [NUM_WIDTH+1:0] i_x,
    input  logic signed [NUM_WIDTH+1:0] i_y,
    input  logic        [NUM_WIDTH-1:0] i_z,
    input  logic        [CNT_W-1:0]     i_k,
    input  logic        [NUM_WIDTH-1:0] i_atan_k,
    output logic signed [NUM_WIDTH+1:0] o_x,
    output logic signed [NUM_WIDTH+1:0] o_y,
    output logic        [NUM_WIDTH-1:0] o_z
);
    logic signed [NUM_WIDTH+1:0] w_x_sh;
    logic signed [NUM_WIDTH+1:0] w_y_sh;

    assign w_x_sh = i_x >>> i_k;
    assign w_y_sh = i_y >>> i_k;

    always_comb begin
        if (!i_y[NUM_WIDTH+1]) begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + i_atan_k;
        end else begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - i_atan_k;
        end
    end

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring CORDIC: (x, y) -> magnitude and atan2 binary angle, one micro-rotation
// per cycle. Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation cycle before DONE.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int NUM_WIDTH = 24,
    parameter int ITER      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [NUM_WIDTH-1:0]   i_x,
    input  logic [NUM_WIDTH-1:0]   i_y,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [NUM_WIDTH+1:0]   o_mag,
    output logic [NUM_WIDTH-1:0]   o_angle
);
    localparam int XW    = NUM_WIDTH + 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0]     LAST_K = CNT_W'(ITER - 1);
    localparam logic [NUM_WIDTH-1:0] ANG90  = NUM_WIDTH'(angle_90(NUM_WIDTH));
`ifdef CORDIC_GAIN_COMP_EN
    localparam cordic_state_e ST_AFTER_ITER = ST_COMP;
`else
    localparam cordic_state_e ST_AFTER_ITER = ST_DONE;
`endif

    cordic_state_e r_state, w_state_next;
    logic signed [XW-1:0]    r_x, r_y;
    logic [NUM_WIDTH-1:0]    r_z;
    logic [CNT_W-1:0]        r_k;
    logic                    r_zero;

    logic signed [XW-1:0]    w_x_ext, w_y_ext, w_x_pre, w_y_pre, w_x_rot, w_y_rot;
    logic [NUM_WIDTH-1:0]    w_z_pre, w_z_rot;
    logic                    w_i_ready, w_o_valid;
    logic [NUM_WIDTH-1:0]    w_atan_tab [ITER];

    for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
        assign w_atan_tab[gi] = NUM_WIDTH'(atan_angle(gi, NUM_WIDTH));
    end

    assign w_x_ext = {{2{i_x[NUM_WIDTH-1]}}, i_x};
    assign w_y_ext = {{2{i_y[NUM_WIDTH-1]}}, i_y};

    // Fold the left half-plane into the right so the iterations always converge
    always_comb begin
        w_x_pre = w_x_ext;
        w_y_pre = w_y_ext;
        w_z_pre = '0;
        if (w_x_ext[XW-1]) begin
            if (!w_y_ext[XW-1]) begin
                w_x_pre = w_y_ext;
                w_y_pre = -w_x_ext;
                w_z_pre = ANG90;
            end else begin
                w_x_pre = -w_y_ext;
                w_y_pre = w_x_ext;
                w_z_pre = '0 - ANG90;
            end
        end
    end

    cordic_vec_microrot #(
        .NUM_WIDTH (NUM_WIDTH),
        .CNT_W     (CNT_W)
    ) u_microrot (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_z      (r_z),
        .i_k      (r_k),
        .i_atan_k (w_atan_tab[r_k]),
        .o_x      (w_x_rot),
        .o_y      (w_y_rot),
        .o_z      (w_z_rot)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = XW + NUM_WIDTH;
    localparam logic [NUM_WIDTH-1:0] INV_GAIN = NUM_WIDTH'(inv_gain(NUM_WIDTH));
    localparam logic [PW-1:0]        HALF_LSB = PW'(1) << (NUM_WIDTH - 1);
    logic signed [XW-1:0] w_x_comp;
    // x is non-negative here, so an unsigned multiply with half-up rounding is exact enough
    assign w_x_comp = XW'((({{NUM_WIDTH{1'b0}}, r_x} * {{XW{1'b0}}, INV_GAIN}) + HALF_LSB)
                          >> NUM_WIDTH);
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_i_ready    = 1'b0;
        w_o_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_i_ready = 1'b1;
                if (i_valid) w_state_next = ST_ITER;
            end
            ST_ITER: begin
                if (r_k == LAST_K) w_state_next = ST_AFTER_ITER;
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_COMP: w_state_next = ST_DONE;
`endif
            ST_DONE: begin
                w_o_valid = 1'b1;
                if (o_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_k    <= '0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_x    <= w_x_pre;
                        r_y    <= w_y_pre;
                        r_z    <= w_z_pre;
                        r_k    <= '0;
                        r_zero <= (i_x == '0) && (i_y == '0);
                    end
                end
                ST_ITER: begin
                    r_x <= w_x_rot;
                    r_y <= w_y_rot;
                    r_z <= w_z_rot;
                    r_k <= r_k + CNT_W'(1);
                end
`ifdef CORDIC_GAIN_COMP_EN
                ST_COMP: r_x <= w_x_comp;
`endif
                default: ;
            endcase
        end
    end

    assign i_ready = w_i_ready;
    assign o_valid = w_o_valid;
    assign o_mag   = w_o_valid ? $unsigned(r_x) : '0;
    // Angle of a zero vector is undefined; report 0 instead of the accumulated z
    assign o_angle = (w_o_valid && !r_zero) ? r_z : '0;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Scoreboard bench for cordic_vector_iter: directed vectors with hand-computed angle/magnitude.
module tb_cordic_vector_iter;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = 17;
    localparam bit COMP = 1'b1;
`else
    localparam int LAT  = 16;
    localparam bit COMP = 1'b0;
`endif

    typedef struct {
        int mag;
        int ang;
        int mtol;
        int atol;
        int acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [23:0] i_x = '0;
    logic [23:0] i_y = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [25:0] o_mag;
    logic [23:0] o_angle;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_txn    = 0;
    exp_t sb[$];

    cordic_vector_iter #(.NUM_WIDTH(24), .ITER(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_x     (i_x),
        .i_y     (i_y),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_mag   (o_mag),
        .o_angle (o_angle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    endtask

    // Monitor: latency, hold stability, busy ready, and scoreboard compare on handshake
    initial begin
        bit          prev_valid = 1'b0;
        bit          prev_hs    = 1'b0;
        logic [25:0] held_mag   = '0;
        logic [23:0] held_ang   = '0;
        int          lat        = 0;
        forever begin
            @(negedge clk);
            if (prev_hs) chk(i_ready, "ready_after_done", int'(i_ready), 1);
            if (o_valid && !prev_valid) begin
                chk(sb.size() != 0, "unexpected_valid", sb.size(), 1);
                if (sb.size() != 0) begin
                    lat = cyc - sb[0].acc;
                    chk(lat == LAT, "latency", lat, LAT);
                end
                held_mag = o_mag;
                held_ang = o_angle;
            end else if (o_valid) begin
                chk(o_mag == held_mag, "hold_mag", int'(o_mag), int'(held_mag));
                chk(o_angle == held_ang, "hold_angle", int'(o_angle), int'(held_ang));
            end
            if (o_valid) chk(!i_ready, "busy_ready", int'(i_ready), 0);
            if (o_valid && o_ready && sb.size() != 0) begin
                exp_t        e;
                int          dm;
                int          da;
                logic [23:0] d24;
                e   = sb.pop_front();
                dm  = int'(o_mag) - e.mag;
                if (dm < 0) dm = -dm;
                d24 = o_angle - 24'(e.ang);
                da  = int'($signed(d24));
                if (da < 0) da = -da;
                chk(dm <= e.mtol, "mag", int'(o_mag), e.mag);
                chk(da <= e.atol, "angle", int'(o_angle), e.ang);
                n_txn++;
                $display("txn %0d: mag=%0d angle=0x%06h latency=%0d", n_txn, o_mag, o_angle, lat);
            end
            prev_valid = o_valid;
            prev_hs    = o_valid && o_ready;
        end
    end

    task automatic send(input int x, input int y, input int ang, input int mag_k, input int mag_c,
                        input int mtol, input int atol, input int hold);
        exp_t e;
        int   t;
        t = 0;
        while (!i_ready && t < 100) begin @(negedge clk); t++; end
        chk(i_ready, "accept_wait", int'(i_ready), 1);
        i_x     = 24'(x);
        i_y     = 24'(y);
        i_valid = 1'b1;
        if (hold > 0) o_ready = 1'b0;
        e.mag  = COMP ? mag_c : mag_k;
        e.ang  = ang;
        e.mtol = mtol;
        e.atol = atol;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
        if (hold > 0) begin
            t = 0;
            while (!o_valid && t < 100) begin @(negedge clk); t++; end
            repeat (hold) @(posedge clk);
            #1 o_ready = 1'b1;
        end
        t = 0;
        while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
        chk(sb.size() == 0, "done_wait", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk(i_ready == 1'b1, "rst_i_ready", int'(i_ready), 1);
        chk(o_valid == 1'b0, "rst_o_valid", int'(o_valid), 0);
        chk(o_mag == '0, "rst_o_mag", int'(o_mag), 0);
        chk(o_angle == '0, "rst_o_angle", int'(o_angle), 0);
        rst = 1'b1;
        @(negedge clk);

        //    x          y          angle      K*|v|     |v|       mtol atol hold
        send( 1048576,   0,         'h000000,  1726753,  1048576,  32, 128, 0);
        send( 1048576,   1048576,   'h200000,  2441998,  1482910,  32, 128, 0);
        send(-1048576,   0,         'h800000,  1726753,  1048576,  32, 128, 0);
        send(-1048576,  -1,         'h800000,  1726753,  1048576,  32, 128, 0);
        send( 0,        -1048576,   'hC00000,  1726753,  1048576,  32, 128, 0);
        send(-8388608,  -8388608,   'hA00000,  19535984, 11863283, 64, 128, 0);
        send( 0,         1048576,   'h400000,  1726753,  1048576,  32, 128, 10);
        send( 0,         0,         'h000000,  0,        0,        0,  0,   0);

        // Reset while step k=7 is in flight: vector must be discarded
        i_x     = 24'd1048576;
        i_y     = 24'd0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(i_ready == 1'b1, "midrst_i_ready", int'(i_ready), 1);
        chk(o_valid == 1'b0, "midrst_o_valid", int'(o_valid), 0);
        chk(o_mag == '0, "midrst_o_mag", int'(o_mag), 0);
        chk(o_angle == '0, "midrst_o_angle", int'(o_angle), 0);
        rst = 1'b1;
        repeat (30) @(negedge clk);

        send(-1048576,   1048576,   'h600000,  2441998,  1482910,  32, 128, 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
